gate_seq: RTL and testbench
===========================

Name: gate_seq

Overview:
- Sequences garbled-gate evaluation between the SPI gate decoder, the label array controller (label_ctl) and the AES core.
- Replaces the ad-hoc gate state machine in the top level and adds the AND-gate path: start AES, buffer ciphertexts, XOR, store.
- Adds protocol error detection, a watchdog and a completed-gate counter.

Parameters:
LABEL_W, 128, label / ciphertext / AES block width
TIMEOUT, 1024, max cycles spent in FETCH, AES_WAIT or CTXT_WAIT before abort

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
gate_type  in  2  0=AND, 1=XOR, 2=BUF, 3=invalid; valid at id strobes
id_1_strobe  in  1  first input id decoded
id_2_strobe  in  1  second input id decoded
ctxt_strobe  in  1  ciphertext word valid
ctxt_idx  in  2  row index of ctxt
ctxt  in  LABEL_W  ciphertext row
gate_id_strobe  in  1  output wire id decoded
l_ctl_done  in  1  label_ctl fetch complete; label_out and ctxt_point valid
label_out  in  LABEL_W  fetched / combined label
ctxt_point  in  2  point-and-permute row select
aes_done  in  1  AES result valid (1-cycle pulse)
aes_out  in  LABEL_W  AES result
aes_start  out  1  1-cycle start pulse to AES
l_ctl_store  out  1  1-cycle store pulse to label_ctl
new_label  out  LABEL_W  label to store
busy  out  1  state != IDLE
error  out  1  sticky protocol/timeout error
err_clear  in  1  clears error
gates_done  out  24  count of stored gates, wraps

Behaviour:
Reset (synchronous, rst=1 at clk edge): state=IDLE; aes_start, l_ctl_store, error, busy=0; new_label=0; gates_done=0; ctxt_valid[3:0]=0; gid_pending=0; timer=0.

States:
- IDLE: (gate_type==BUF & id_1_strobe) or (gate_type∈{AND,XOR} & id_2_strobe) -> FETCH. Strobe with gate_type==3 -> error=1, stay IDLE. id_1_strobe for AND/XOR is ignored.
- FETCH: on l_ctl_done, new_label<=label_out.
  - AND: latch ctxt_point into pt -> AES_START.
  - XOR/BUF -> ID_WAIT.
- AES_START: aes_start=1 for exactly this cycle -> AES_WAIT. AES state_init is label_out, held stable by label_ctl.
- AES_WAIT: on aes_done:
  - if ctxt_valid[pt]: new_label<=aes_out^cbuf[pt] -> ID_WAIT.
  - else: new_label<=aes_out -> CTXT_WAIT.
- CTXT_WAIT: once ctxt_valid[pt] (buffered earlier or arriving this cycle, bypass allowed): new_label<=new_label^ciphertext -> ID_WAIT.
- ID_WAIT: if gid_pending or gate_id_strobe -> STORE.
- STORE: l_ctl_store=1 for this cycle; gates_done+=1; clear gid_pending and ctxt_valid -> IDLE.

Latency:
- XOR/BUF: store pulse 2 cycles after l_ctl_done when gate_id is already pending.
- AND: store pulse 2 cycles after aes_done when ctxt and gate_id are buffered.

Ciphertext buffer:
- 4 x LABEL_W entries; ctxt_strobe writes cbuf[ctxt_idx] and sets ctxt_valid[ctxt_idx] in any state.
- Rewriting a valid entry before STORE -> error=1; new data overwrites.
- ctxt_strobe in the STORE cycle belongs to the next gate: set wins over clear.
- XOR/BUF gates ignore buffered ctxts; buffer is cleared at STORE.

gate_id handling:
- gate_id_strobe in any non-IDLE state before ID_WAIT sets gid_pending.
- A second strobe while pending -> error=1.
- gate_id_strobe in IDLE -> error=1, ignored.

Errors and watchdog:
- id_1/id_2 strobe while busy -> error=1; strobe ignored; current gate continues.
- Timer counts cycles in FETCH/AES_WAIT/CTXT_WAIT and resets on state change. Reaching TIMEOUT -> error=1, abort to IDLE, clear buffers and gid_pending, no store.
- err_clear clears error. A simultaneous new error wins: error stays 1.
- rst mid-operation aborts immediately; no store pulse is issued.
- gates_done wraps from 0xFFFFFF to 0.

Test Plan:
- XOR: gate_type=1, id_2_strobe, l_ctl_done with label_out=0x55..55 after 3 cycles, gate_id_strobe -> one l_ctl_store pulse, new_label=0x55..55, gates_done=1, aes_start never asserted.
- AND with early ctxts: ctxts idx0..3 = 0x10..,0x20..,0x30..,0x40.. sent first; l_ctl_done with ctxt_point=2; aes_done with aes_out=0xFF..FF -> exactly one aes_start pulse, new_label=0xCF..CF, store 2 cycles after aes_done once gate_id is pending.
- AND with late ctxt: aes_done precedes ctxt idx=1 (pt=1, ctxt=0x0F..0F, aes_out=0xF0..F0) -> CTXT_WAIT, then new_label=0xFF..FF, store follows.
- BUF plus early gate_id: gate_type=2, id_1_strobe, gate_id_strobe, then l_ctl_done -> store 2 cycles after l_ctl_done, error=0.
- Errors: gate_type=3 strobe -> error=1, busy=0; err_clear -> 0; id_2_strobe during AES_WAIT -> error=1, the first gate still stores once.
- Timeout/reset: TIMEOUT=16, aes_done withheld -> error=1 at cycle 16 in AES_WAIT, IDLE, no store; separately rst during CTXT_WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/gate_seq.sv
// rtl/gate_seq.sv - garbled-gate evaluation sequencer between gate decoder, label_ctl and AES
module gate_seq #(
    parameter int LABEL_W = 128,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         gate_type,
    input  logic               id_1_strobe,
    input  logic               id_2_strobe,
    input  logic               ctxt_strobe,
    input  logic [1:0]         ctxt_idx,
    input  logic [LABEL_W-1:0] ctxt,
    input  logic               gate_id_strobe,
    input  logic               l_ctl_done,
    input  logic [LABEL_W-1:0] label_out,
    input  logic [1:0]         ctxt_point,
    input  logic               aes_done,
    input  logic [LABEL_W-1:0] aes_out,
    output logic               aes_start,
    output logic               l_ctl_store,
    output logic [LABEL_W-1:0] new_label,
    output logic               busy,
    output logic               error,
    input  logic               err_clear,
    output logic [23:0]        gates_done
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] G_AND = 2'd0;
    localparam logic [1:0] G_BUF = 2'd2;
    localparam logic [1:0] G_BAD = 2'd3;

    typedef enum logic [2:0] {
        IDLE, FETCH, AES_START, AES_WAIT, CTXT_WAIT, ID_WAIT, STORE
    } state_t;

    state_t             state, state_n;
    logic [1:0]         gtype;
    logic [1:0]         pt;
    logic [LABEL_W-1:0] cbuf [4];
    logic [3:0]         ctxt_valid;
    logic               gid_pending;
    logic [TW-1:0]      timer;

    logic               err_set, label_we, abort, timed, id_strobe;
    logic               ctxt_bypass, gid_set, clear_buf;
    logic [LABEL_W-1:0] label_n, ctxt_word;

    assign aes_start   = (state == AES_START);
    assign l_ctl_store = (state == STORE);
    assign busy        = (state != IDLE);
    assign id_strobe   = id_1_strobe | id_2_strobe;
    assign timed       = (state == FETCH) || (state == AES_WAIT) || (state == CTXT_WAIT);
    // A ciphertext arriving in the same cycle it is needed is used directly.
    assign ctxt_bypass = ctxt_strobe && (ctxt_idx == pt);
    assign ctxt_word   = ctxt_bypass ? ctxt : cbuf[pt];
    assign gid_set     = gate_id_strobe && timed || gate_id_strobe && (state == AES_START);
    assign clear_buf   = (state == STORE) || abort;

    always_comb begin
        state_n  = state;
        err_set  = 1'b0;
        label_we = 1'b0;
        label_n  = new_label;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (id_strobe && gate_type == G_BAD)
                    err_set = 1'b1;
                else if ((gate_type == G_BUF && id_1_strobe) ||
                         (gate_type != G_BUF && id_2_strobe))
                    state_n = FETCH;
                if (gate_id_strobe)
                    err_set = 1'b1;
            end
            FETCH: if (l_ctl_done) begin
                label_we = 1'b1;
                label_n  = label_out;
                state_n  = (gtype == G_AND) ? AES_START : ID_WAIT;
            end
            AES_START: state_n = AES_WAIT;
            AES_WAIT: if (aes_done) begin
                label_we = 1'b1;
                if (ctxt_valid[pt]) begin
                    label_n = aes_out ^ cbuf[pt];
                    state_n = ID_WAIT;
                end else begin
                    label_n = aes_out;
                    state_n = CTXT_WAIT;
                end
            end
            CTXT_WAIT: if (ctxt_valid[pt] || ctxt_bypass) begin
                label_we = 1'b1;
                label_n  = new_label ^ ctxt_word;
                state_n  = ID_WAIT;
            end
            ID_WAIT: if (gid_pending || gate_id_strobe) state_n = STORE;
            STORE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (timed && state_n == state && timer == TW'(TIMEOUT - 1)) begin
            abort   = 1'b1;
            err_set = 1'b1;
            state_n = IDLE;
        end
        if (state != IDLE && id_strobe)
            err_set = 1'b1;
        if (ctxt_strobe && ctxt_valid[ctxt_idx] && state != STORE)
            err_set = 1'b1;
        if (gate_id_strobe && state != IDLE && (gid_pending || state == STORE))
            err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gtype       <= G_AND;
            pt          <= 2'd0;
            new_label   <= '0;
            error       <= 1'b0;
            gates_done  <= 24'd0;
            ctxt_valid  <= 4'd0;
            gid_pending <= 1'b0;
            timer       <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == FETCH)
                gtype <= gate_type;
            if (state == FETCH && l_ctl_done)
                pt <= ctxt_point;
            if (label_we)
                new_label <= label_n;
            error <= err_set | (error & ~err_clear);
            if (state == STORE)
                gates_done <= gates_done + 24'd1;
            // A strobe in the clearing cycle belongs to the next gate, so set wins.
            ctxt_valid <= (clear_buf ? 4'd0 : ctxt_valid) |
                          (ctxt_strobe ? (4'd1 << ctxt_idx) : 4'd0);
            if (clear_buf)
                gid_pending <= 1'b0;
            else if (gid_set)
                gid_pending <= 1'b1;
            if (!timed || state_n != state)
                timer <= '0;
            else
                timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ctxt_strobe)
            cbuf[ctxt_idx] <= ctxt;
    end
endmodule

// File: tb/tb_gate_seq.sv
// tb/tb_gate_seq.sv - self-checking bench for gate_seq
module tb_gate_seq;
    localparam int W = 128;

    logic         clk = 1'b0;
    logic         rst, id_1_strobe, id_2_strobe, ctxt_strobe, gate_id_strobe;
    logic         l_ctl_done, aes_done, err_clear;
    logic [1:0]   gate_type, ctxt_idx, ctxt_point;
    logic [W-1:0] ctxt, label_out, aes_out;
    logic         aes_start, l_ctl_store, busy, error;
    logic [W-1:0] new_label;
    logic [23:0]  gates_done;

    gate_seq #(.LABEL_W(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .gate_type(gate_type),
        .id_1_strobe(id_1_strobe), .id_2_strobe(id_2_strobe),
        .ctxt_strobe(ctxt_strobe), .ctxt_idx(ctxt_idx), .ctxt(ctxt),
        .gate_id_strobe(gate_id_strobe), .l_ctl_done(l_ctl_done),
        .label_out(label_out), .ctxt_point(ctxt_point),
        .aes_done(aes_done), .aes_out(aes_out),
        .aes_start(aes_start), .l_ctl_store(l_ctl_store),
        .new_label(new_label), .busy(busy), .error(error),
        .err_clear(err_clear), .gates_done(gates_done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, n_aes = 0, n_store = 0;
    int done_cyc = 0, aesd_cyc = 0, store_cyc = 0;
    logic [W-1:0] store_label = '0;
    int exp_gates = 0;

    always @(posedge clk) begin
        cyc++;
        if (aes_start) n_aes++;
        if (l_ctl_store) begin
            n_store++;
            store_cyc   = cyc;
            store_label = new_label;
        end
        if (l_ctl_done) done_cyc = cyc;
        if (aes_done) aesd_cyc = cyc;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]   gt;
        logic [W-1:0] label;
        logic [1:0]   pt;
        logic [W-1:0] aes;
        logic         early_ctxt;
        logic [W-1:0] late_ctxt;
        logic         gid_early;
        logic [W-1:0] exp_label;
        int           exp_aes;
        int           lat_ref;   // 0 none, 1 from l_ctl_done, 2 from aes_done
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [1:0] gt, input logic [W-1:0] label,
                                input logic [1:0] pt, input logic [W-1:0] aes,
                                input logic early, input logic [W-1:0] late,
                                input logic gid_early, input logic [W-1:0] exp_label,
                                input int exp_aes, input int lat_ref);
        vec_t v;
        v.gt = gt; v.label = label; v.pt = pt; v.aes = aes;
        v.early_ctxt = early; v.late_ctxt = late; v.gid_early = gid_early;
        v.exp_label = exp_label; v.exp_aes = exp_aes; v.lat_ref = lat_ref;
        return v;
    endfunction

    task automatic wait_store(input int s_store, input string name);
        for (int k = 0; k < 30 && n_store == s_store; k++) tick();
        if (n_store == s_store) begin
            checks++;
            failures++;
            $display("FAIL %s: no store pulse within 30 cycles", name);
        end
    endtask

    task automatic start_gate(input logic [1:0] gt);
        gate_type = gt;
        if (gt == 2'd2) id_1_strobe = 1'b1; else id_2_strobe = 1'b1;
        tick();
        id_1_strobe = 1'b0;
        id_2_strobe = 1'b0;
    endtask

    task automatic send_ctxt(input logic [1:0] idx, input logic [W-1:0] val);
        ctxt_strobe = 1'b1; ctxt_idx = idx; ctxt = val;
        tick();
        ctxt_strobe = 1'b0;
    endtask

    task automatic pulse_gid();
        gate_id_strobe = 1'b1;
        tick();
        gate_id_strobe = 1'b0;
    endtask

    task automatic fetch_done(input logic [W-1:0] lbl, input logic [1:0] p);
        l_ctl_done = 1'b1; label_out = lbl; ctxt_point = p;
        tick();
        l_ctl_done = 1'b0;
    endtask

    task automatic give_aes(input logic [W-1:0] val);
        aes_done = 1'b1; aes_out = val;
        tick();
        aes_done = 1'b0;
    endtask

    task automatic run_gate(input vec_t v, input int idx);
        int s_store, s_aes;
        string tag;
        tag = $sformatf("vec%0d", idx);
        s_store = n_store;
        s_aes   = n_aes;
        if (v.early_ctxt)
            for (int i = 0; i < 4; i++) send_ctxt(2'(i), {16{8'((i + 1) * 16)}});
        start_gate(v.gt);
        if (v.gid_early) pulse_gid();
        tick(2);
        fetch_done(v.label, v.pt);
        if (v.gt == 2'd0) begin
            tick(2);
            give_aes(v.aes);
            if (!v.early_ctxt) begin
                tick(2);
                send_ctxt(v.pt, v.late_ctxt);
            end
        end
        if (!v.gid_early) begin
            tick();
            pulse_gid();
        end
        wait_store(s_store, {tag, "_wait"});
        tick(2);
        exp_gates++;
        chk({tag, "_stores"}, W'(n_store - s_store), W'(1));
        chk({tag, "_label"}, store_label, v.exp_label);
        chk({tag, "_aes_starts"}, W'(n_aes - s_aes), W'(v.exp_aes));
        if (v.lat_ref == 1) chk({tag, "_latency"}, W'(store_cyc - done_cyc), W'(2));
        if (v.lat_ref == 2) chk({tag, "_latency"}, W'(store_cyc - aesd_cyc), W'(2));
        chk({tag, "_gates_done"}, W'(gates_done), W'(exp_gates));
        chk({tag, "_idle"}, W'({busy, error}), W'(0));
    endtask

    initial begin
        int s_store, s_aes;
        vecs[0] = mk(2'd1, {16{8'h55}}, 2'd0, '0, 1'b0, '0, 1'b0, {16{8'h55}}, 0, 0);
        vecs[1] = mk(2'd0, {16{8'hAA}}, 2'd2, {16{8'hFF}}, 1'b1, '0, 1'b1, {16{8'hCF}}, 1, 2);
        vecs[2] = mk(2'd0, {16{8'h33}}, 2'd1, {16{8'hF0}}, 1'b0, {16{8'h0F}}, 1'b0, {16{8'hFF}}, 1, 0);
        vecs[3] = mk(2'd2, {8{16'h1234}}, 2'd3, '0, 1'b0, '0, 1'b1, {8{16'h1234}}, 0, 1);
        vecs[4] = mk(2'd1, {16{8'hC3}}, 2'd0, '0, 1'b1, '0, 1'b1, {16{8'hC3}}, 0, 1);
        vecs[5] = mk(2'd0, '0, 2'd0, {4{32'hDEADBEEF}}, 1'b1, '0, 1'b1, {4{32'hCEBDAEFF}}, 1, 2);

        rst = 1'b1; gate_type = 2'd0; id_1_strobe = 1'b0; id_2_strobe = 1'b0;
        ctxt_strobe = 1'b0; ctxt_idx = 2'd0; ctxt = '0; gate_id_strobe = 1'b0;
        l_ctl_done = 1'b0; label_out = '0; ctxt_point = 2'd0; aes_done = 1'b0;
        aes_out = '0; err_clear = 1'b0;
        tick(2);
        chk("reset_outputs", W'({aes_start, l_ctl_store, busy, error}), W'(0));
        chk("reset_label", new_label, '0);
        chk("reset_gates", W'(gates_done), W'(0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_gate(vecs[i], i);

        // invalid gate type
        gate_type = 2'd3; id_2_strobe = 1'b1; tick(); id_2_strobe = 1'b0;
        chk("bad_type_error", W'(error), W'(1));
        chk("bad_type_busy", W'(busy), W'(0));
        err_clear = 1'b1; tick(); err_clear = 1'b0;
        chk("err_clear", W'(error), W'(0));

        // id strobe while busy; first gate must still complete once
        s_store = n_store;
        start_gate(2'd0);
        tick(2);
        fetch_done('0, 2'd0);
        tick(2);
        gate_type = 2'd1; id_2_strobe = 1'b1; tick(); id_2_strobe = 1'b0;
        chk("busy_strobe_error", W'({busy, error}), W'(3));
        give_aes({16{8'h5A}});
        send_ctxt(2'd0, {16{8'hA5}});
        pulse_gid();
        wait_store(s_store, "busy_strobe_wait");
        tick(5);
        exp_gates++;
        chk("busy_strobe_stores", W'(n_store - s_store), W'(1));
        chk("busy_strobe_label", store_label, {16{8'hFF}});
        chk("busy_strobe_gates", W'(gates_done), W'(exp_gates));

        // new error in the err_clear cycle keeps error set
        gate_id_strobe = 1'b1; err_clear = 1'b1; tick();
        gate_id_strobe = 1'b0;
        chk("clear_vs_set", W'(error), W'(1));
        tick(); err_clear = 1'b0;
        chk("clear_after", W'(error), W'(0));

        // rewriting a valid ciphertext entry
        send_ctxt(2'd3, {16{8'h01}});
        chk("ctxt_first_write", W'(error), W'(0));
        send_ctxt(2'd3, {16{8'h02}});
        chk("ctxt_rewrite_error", W'(error), W'(1));
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // watchdog in AES_WAIT
        s_store = n_store; s_aes = n_aes;
        start_gate(2'd0);
        tick(2);
        fetch_done({16{8'h11}}, 2'd3);
        tick();
        tick(15);
        chk("timeout_not_yet", W'({busy, error}), W'(2));
        tick();
        chk("timeout_abort", W'({busy, error}), W'(1));
        tick(3);
        chk("timeout_no_store", W'(n_store - s_store), W'(0));
        chk("timeout_aes_once", W'(n_aes - s_aes), W'(1));
        chk("timeout_gates", W'(gates_done), W'(exp_gates));
        err_clear = 1'b1; tick(); err_clear = 1'b0;

        // reset during CTXT_WAIT
        s_store = n_store;
        start_gate(2'd0);
        tick(2);
        fetch_done({16{8'h22}}, 2'd1);
        tick(2);
        give_aes({16{8'h77}});
        pulse_gid();
        send_ctxt(2'd2, {16{8'h03}});
        send_ctxt(2'd2, {16{8'h04}});
        chk("pre_reset_state", W'({busy, error}), W'(3));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_outputs", W'({aes_start, l_ctl_store, busy, error}), W'(0));
        chk("rst_label", new_label, '0);
        chk("rst_gates", W'(gates_done), W'(0));
        tick(4);
        chk("rst_no_store", W'(n_store - s_store), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
